// File: rtl/rf_prbs_checker_if.sv
// Stream-side bundle for the PRBS checker: received bit stream and control in,
// lock/error status out.
interface rf_prbs_checker_if;
  logic        en;
  logic        poly_sel;
  logic        din_valid;
  logic        din;
  logic        clr;
  logic        locked;
  logic        err_pulse;
  logic [15:0] err_cnt;
  logic [23:0] bit_cnt;

  modport master (
    output en, poly_sel, din_valid, din, clr,
    input  locked, err_pulse, err_cnt, bit_cnt
  );

  modport slave (
    input  en, poly_sel, din_valid, din, clr,
    output locked, err_pulse, err_cnt, bit_cnt
  );
endinterface

// File: rtl/rf_prbs_checker.sv
// Serial PRBS7/PRBS15 checker: hunts for lock on the received stream, then
// free-runs its own history and counts bit errors with windowed loss detection.
module rf_prbs_checker #(
  parameter int LOCK_THRESH = 32,
  parameter int LOSS_THRESH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  rf_prbs_checker_if.slave  bus
);

  typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_t;

  localparam logic [6:0] LOCK_T = 7'(LOCK_THRESH);
  localparam logic [6:0] LOSS_T = 7'(LOSS_THRESH);

  state_t      state_reg;
  logic [14:0] sr_reg;
  logic [5:0]  match_reg;
  logic [5:0]  win_reg;
  logic [6:0]  win_err_reg;
  logic [15:0] err_cnt_reg;
  logic [23:0] bit_cnt_reg;
  logic        err_pulse_reg;

  logic       accept;
  logic       pred;
  logic       tap_zero;
  logic       bit_err;
  logic [6:0] match_next;
  logic [6:0] win_err_next;

  assign accept       = bus.en & bus.din_valid;
  assign pred         = bus.poly_sel ? (sr_reg[14] ^ sr_reg[13]) : (sr_reg[6] ^ sr_reg[5]);
  // An all-zero tap window predicts 0 forever, so a stuck-low line would lock.
  assign tap_zero     = bus.poly_sel ? (sr_reg == 15'd0) : (sr_reg[6:0] == 7'd0);
  assign bit_err      = bus.din ^ pred;
  assign match_next   = {1'b0, match_reg} + 7'd1;
  assign win_err_next = win_err_reg + {6'd0, bit_err};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= HUNT;
      sr_reg        <= '0;
      match_reg     <= '0;
      win_reg       <= '0;
      win_err_reg   <= '0;
      err_cnt_reg   <= '0;
      bit_cnt_reg   <= '0;
      err_pulse_reg <= 1'b0;
    end else begin
      err_pulse_reg <= 1'b0;

      if (!bus.en) begin
        state_reg   <= HUNT;
        match_reg   <= '0;
        win_reg     <= '0;
        win_err_reg <= '0;
      end else if (bus.din_valid) begin
        case (state_reg)
          HUNT: begin
            sr_reg <= {sr_reg[13:0], bus.din};
            if (!bit_err && !tap_zero) begin
              if (match_next == LOCK_T) begin
                state_reg   <= LOCKED;
                match_reg   <= '0;
                win_reg     <= '0;
                win_err_reg <= '0;
              end else begin
                match_reg <= match_next[5:0];
              end
            end else begin
              match_reg <= '0;
            end
          end
          LOCKED: begin
            // Shift in the prediction so one bad bit cannot corrupt later predictions.
            sr_reg  <= {sr_reg[13:0], pred};
            win_reg <= win_reg + 6'd1;
            if (bit_err)
              err_pulse_reg <= 1'b1;
            if (win_err_next == LOSS_T) begin
              state_reg   <= HUNT;
              match_reg   <= '0;
              win_reg     <= '0;
              win_err_reg <= '0;
            end else if (win_reg == 6'd63) begin
              win_err_reg <= '0;
            end else begin
              win_err_reg <= win_err_next;
            end
          end
          default: state_reg <= HUNT;
        endcase
      end

      if (bus.clr) begin
        err_cnt_reg <= '0;
        bit_cnt_reg <= '0;
      end else if (accept && state_reg == LOCKED) begin
        if (!(&bit_cnt_reg))
          bit_cnt_reg <= bit_cnt_reg + 24'd1;
        if (bit_err && !(&err_cnt_reg))
          err_cnt_reg <= err_cnt_reg + 16'd1;
      end
    end
  end

  assign bus.locked    = (state_reg == LOCKED);
  assign bus.err_pulse = err_pulse_reg;
  assign bus.err_cnt   = err_cnt_reg;
  assign bus.bit_cnt   = bit_cnt_reg;

endmodule

// File: tb/tb_rf_prbs_checker.sv
// Scoreboard bench for rf_prbs_checker: a history-queue reference model predicts
// the outputs for every driven cycle, and a separate monitor compares them.
module tb_rf_prbs_checker;

  localparam int LOCK_T = 32;
  localparam int LOSS_T = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  rf_prbs_checker_if bus();

  rf_prbs_checker #(.LOCK_THRESH(LOCK_T), .LOSS_THRESH(LOSS_T)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit locked;
    bit pulse;
    int err;
    int bits;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   pulses_seen = 0;
  bit   lock_seen = 1'b0;

  // Reference model: history of accepted bits, most recent at index 0.
  bit m_hist[$];
  bit m_locked;
  int m_run, m_win_pos, m_win_errs, m_err, m_bits;

  // Transmitter: ideal PRBS source, most recent bit at index 0.
  bit tx_hist[$];

  task automatic chk(string name, longint act, longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic void model_reset();
    m_hist = {};
    for (int k = 0; k < 15; k++) m_hist.push_front(1'b0);
    m_locked = 1'b0;
    m_run = 0; m_win_pos = 0; m_win_errs = 0; m_err = 0; m_bits = 0;
  endfunction

  function automatic void tx_seed();
    tx_hist = {};
    for (int k = 0; k < 15; k++) tx_hist.push_front(1'b1);
  endfunction

  function automatic bit tx_next(bit ps);
    int w = ps ? 15 : 7;
    bit b = tx_hist[w-1] ^ tx_hist[w-2];
    tx_hist.push_front(b);
    void'(tx_hist.pop_back());
    return b;
  endfunction

  function automatic void model_step(bit en, bit vld, bit d, bit c, bit ps, output exp_t e);
    int w;
    bit p, z;
    e.pulse = 1'b0;
    if (!en) begin
      m_locked = 1'b0; m_run = 0; m_win_pos = 0; m_win_errs = 0;
    end else if (vld) begin
      w = ps ? 15 : 7;
      p = m_hist[w-1] ^ m_hist[w-2];
      z = 1'b1;
      for (int k = 0; k < w; k++) if (m_hist[k]) z = 1'b0;
      if (!m_locked) begin
        if (d == p && !z) m_run++; else m_run = 0;
        m_hist.push_front(d);
        if (m_run == LOCK_T) begin
          m_locked = 1'b1; m_run = 0; m_win_pos = 0; m_win_errs = 0;
        end
      end else begin
        m_hist.push_front(p);
        if (m_bits < 24'hFFFFFF) m_bits++;
        m_win_pos++;
        if (d != p) begin
          if (m_err < 65535) m_err++;
          e.pulse = 1'b1;
          m_win_errs++;
        end
        if (m_win_errs == LOSS_T) begin
          m_locked = 1'b0; m_run = 0; m_win_pos = 0; m_win_errs = 0;
        end else if (m_win_pos == 64) begin
          m_win_pos = 0; m_win_errs = 0;
        end
      end
      void'(m_hist.pop_back());
    end
    if (c) begin
      m_err = 0; m_bits = 0;
    end
    e.locked = m_locked;
    e.err    = m_err;
    e.bits   = m_bits;
  endfunction

  task automatic step(bit en, bit vld, bit d, bit c, bit ps);
    exp_t e;
    @(negedge clk);
    bus.en = en; bus.din_valid = vld; bus.din = d; bus.clr = c; bus.poly_sel = ps;
    model_step(en, vld, d, c, ps, e);
    exp_q.push_back(e);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  // Monitor: one expected entry per driven cycle, checked just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (bus.err_pulse === 1'b1) pulses_seen++;
      if (bus.locked === 1'b1) lock_seen = 1'b1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("sb_locked",    bus.locked,    e.locked);
        chk("sb_err_pulse", bus.err_pulse, e.pulse);
        chk("sb_err_cnt",   bus.err_cnt,   e.err);
        chk("sb_bit_cnt",   bus.bit_cnt,   e.bits);
      end
    end
  end

  initial begin
    bit b;
    bit v;
    bus.en = 1'b0; bus.poly_sel = 1'b0; bus.din_valid = 1'b0; bus.din = 1'b0; bus.clr = 1'b0;
    model_reset();
    tx_seed();

    #12;
    chk("rst_locked",    bus.locked,    0);
    chk("rst_err_pulse", bus.err_pulse, 0);
    chk("rst_err_cnt",   bus.err_cnt,   0);
    chk("rst_bit_cnt",   bus.bit_cnt,   0);
    @(negedge clk);
    rst_n = 1'b1;

    // PRBS7, valid every cycle
    step(0, 0, 0, 0, 0);
    tx_seed();
    for (int i = 1; i <= 100; i++) begin
      step(1, 1, tx_next(0), 0, 0);
      if (i == 39) begin
        settle();
        chk("s1_lock_by_39", bus.locked, 1);
      end
    end
    settle();
    chk("s1_locked", bus.locked, 1);
    chk("s1_err_cnt", bus.err_cnt, 0);
    $display("prbs7 lock: locked=%0b err_cnt=%0d bit_cnt=%0d", bus.locked, bus.err_cnt, bus.bit_cnt);

    // PRBS15 with three isolated inverted bits
    step(0, 0, 0, 1, 1);
    tx_seed();
    pulses_seen = 0;
    for (int i = 1; i <= 120; i++) begin
      b = tx_next(1);
      step(1, 1, b ^ (i == 70 || i == 85 || i == 100), 0, 1);
    end
    settle();
    chk("s2_pulses", pulses_seen, 3);
    chk("s2_err_cnt", bus.err_cnt, 3);
    chk("s2_locked", bus.locked, 1);
    $display("prbs15 errors: pulses=%0d err_cnt=%0d locked=%0b", pulses_seen, bus.err_cnt, bus.locked);

    // PRBS7 loss after 8 errors in one window, then relock
    step(0, 0, 0, 1, 0);
    tx_seed();
    for (int i = 1; i <= 50; i++) step(1, 1, tx_next(0), 0, 0);
    for (int i = 1; i <= 8; i++) step(1, 1, ~tx_next(0), 0, 0);
    settle();
    chk("s3_lost", bus.locked, 0);
    chk("s3_err_cnt", bus.err_cnt, 8);
    for (int i = 1; i <= 32; i++) step(1, 1, tx_next(0), 0, 0);
    settle();
    chk("s3_relock", bus.locked, 1);
    $display("prbs7 loss/relock: locked=%0b err_cnt=%0d", bus.locked, bus.err_cnt);

    // Stuck-zero input must never lock
    step(0, 0, 0, 1, 0);
    settle();
    lock_seen = 1'b0;
    for (int i = 1; i <= 200; i++) step(1, 1, 0, 0, 0);
    settle();
    chk("s4_never_locked", lock_seen, 0);
    chk("s4_locked", bus.locked, 0);
    $display("stuck zero: lock_seen=%0b", lock_seen);

    // clr coincident with an errored bit
    step(0, 0, 0, 1, 0);
    tx_seed();
    for (int i = 1; i <= 50; i++) begin
      b = tx_next(0);
      step(1, 1, b ^ (i == 45), 0, 0);
    end
    step(1, 1, ~tx_next(0), 1, 0);
    settle();
    chk("s5_err_cnt", bus.err_cnt, 0);
    chk("s5_err_pulse", bus.err_pulse, 1);
    chk("s5_locked", bus.locked, 1);
    $display("clr with error: err_cnt=%0d err_pulse=%0b", bus.err_cnt, bus.err_pulse);

    // Sparse din_valid, random din on idle cycles, async reset while locked
    step(0, 0, 0, 1, 0);
    tx_seed();
    for (int c = 0; c < 180; c++) begin
      v = (c % 3 == 0);
      b = v ? tx_next(0) : 1'($urandom_range(0, 1));
      step(1, v, b, 0, 0);
    end
    step(1, 1, ~tx_next(0), 0, 0);
    settle();
    chk("s6_locked", bus.locked, 1);
    chk("s6_err_pulse", bus.err_pulse, 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("s6_arst_locked",    bus.locked,    0);
    chk("s6_arst_err_pulse", bus.err_pulse, 0);
    chk("s6_arst_err_cnt",   bus.err_cnt,   0);
    chk("s6_arst_bit_cnt",   bus.bit_cnt,   0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 60; i++) step(1, 1, tx_next(0), 0, 0);
    settle();
    chk("s6_relock", bus.locked, 1);
    $display("sparse valid + reset: locked=%0b bit_cnt=%0d", bus.locked, bus.bit_cnt);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rf_prbs_checker.md
RF_PRBS_CHECKER -- requirements
Module: rf_prbs_checker

Interface
REQ-001 SHALL have parameter LOCK_THRESH, default 32: consecutive correct predictions needed to declare lock (legal range 16..63).
REQ-002 SHALL have parameter LOSS_THRESH, default 8: errors within one 64-bit window that force loss of lock (legal range 1..64).
REQ-003 SHALL have port clk, input, 1: single clock; every register is on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have port en, input, 1: checker enable; low forces HUNT and holds the counters.
REQ-006 SHALL have port poly_sel, input, 1: 0 = PRBS7 (x^7+x^6+1), 1 = PRBS15 (x^15+x^14+1); may change only while en is low.
REQ-007 SHALL have port din_valid, input, 1: din carries a received bit this cycle.
REQ-008 SHALL have port din, input, 1: received serial data bit.
REQ-009 SHALL have port clr, input, 1: synchronous clear of err_cnt and bit_cnt.
REQ-010 SHALL have port locked, output, 1: registered lock flag.
REQ-011 SHALL have port err_pulse, output, 1: one-cycle pulse per errored bit while locked.
REQ-012 SHALL have port err_cnt, output, 16: saturating count of bit errors.
REQ-013 SHALL have port bit_cnt, output, 24: saturating count of bits checked.

Function
REQ-014 SHALL keep a 15-bit history sr; each accepted bit shifts in at sr[0].
REQ-015 SHALL compute the predicted bit pred as sr[6]^sr[5] for PRBS7 and sr[14]^sr[13] for PRBS15.
REQ-016 SHALL accept a bit only on a cycle with en=1 and din_valid=1; on any other cycle sr, the state and all counters hold.
REQ-017 SHALL implement an FSM with two states, HUNT and LOCKED; reset enters HUNT.
REQ-018 HUNT, per accepted bit: sr shifts in din; match counter increments if din==pred, otherwise clears to 0.
REQ-019 HUNT: a match SHALL NOT count when the active tap window (sr[6:0] or sr[14:0]) is all zero; the match counter clears instead, which blocks lock on a stuck-zero input.
REQ-020 HUNT->LOCKED SHALL occur on the accepted bit that brings the match counter to LOCK_THRESH; locked goes high on the next clock edge.
REQ-021 LOCKED, per accepted bit: sr shifts in pred, not din, so the history free-runs; bit_cnt increments.
REQ-022 LOCKED: when din!=pred, err_cnt increments and err_pulse is high for exactly one cycle, registered one cycle after the bit.
REQ-023 LOCKED: a 6-bit window counter SHALL count accepted bits; the window error counter clears when the window counter wraps 63->0.
REQ-024 LOCKED->HUNT SHALL occur on the accepted bit that brings the window error count to LOSS_THRESH; on that transition locked deasserts and the match, window and window-error counters clear.
REQ-025 err_cnt SHALL saturate at 16'hFFFF and bit_cnt at 24'hFFFFFF; neither wraps.
REQ-026 en=0 SHALL force HUNT on the next edge and clear the match counter; err_cnt and bit_cnt hold.
REQ-027 clr=1 SHALL zero err_cnt and bit_cnt on the next edge and has priority over a same-cycle increment; lock state, sr and err_pulse are unaffected.
REQ-028 The loss transition and an error on the same bit: that error SHALL be counted in err_cnt and pulsed on err_pulse.

Reset
REQ-029 While rst_n is low, all outputs SHALL be 0: locked=0, err_pulse=0, err_cnt=0, bit_cnt=0.
REQ-030 Reset SHALL take effect asynchronously, including mid-stream and in LOCKED, clearing sr, all counters and the FSM (FSM to HUNT); release is synchronous to clk.

Verification
REQ-031 Bench SHALL cover: PRBS7 seeded 7'h7F, poly_sel=0, din_valid=1 every cycle -> locked rises no later than bit 7+32 and stays high; err_cnt=0; bit_cnt increments by 1 per bit.
REQ-032 Bench SHALL cover: PRBS15 locked, invert 3 isolated bits -> exactly 3 err_pulse pulses, err_cnt=3, locked stays 1.
REQ-033 Bench SHALL cover: locked PRBS7, then 8 errors within one 64-bit window -> locked=0 one cycle after the 8th error; relock after 32 clean bits.
REQ-034 Bench SHALL cover: din held at 0 for 200 valid bits -> locked never rises.
REQ-035 Bench SHALL cover: clr asserted on the same cycle as an errored bit -> err_cnt=0 next cycle, err_pulse still pulses.
REQ-036 Bench SHALL cover: din_valid toggling 1-in-3 with a PRBS7 stream and rst_n pulsed low while locked -> lock reached on valid bits only; the reset clears all outputs asynchronously.
